// File: rtl/proc_seq_ctrl.sv
// Instruction sequencer: fetches words over a req/ack handshake, loads the IR and
// walks each instruction through DECODE/EXEC/WB, holding mul in EXEC for MUL_LAT cycles.
module proc_seq_ctrl #(
    parameter int         ADDR_W  = 8,
    parameter int         MUL_LAT = 3,
    parameter logic [4:0] HALT_OP = 5'b11111
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              stop,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir,
    output logic [ADDR_W-1:0] pc,
    output logic              exec_en,
    output logic              gpr_we,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [15:0]       retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    localparam logic [4:0] OP_MUL  = 5'd4;
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              stop_q, stop_d;
    logic              err_q, err_d;
    logic [15:0]       retired_q, retired_d;
    logic              imem_req_q, exec_en_q, gpr_we_q, busy_q, halted_q;

    logic [4:0] oper_type;
    logic       stop_go;

    assign oper_type = ir_q[31:27];
    // A stop seen in the same cycle as the exit decision counts as latched.
    assign stop_go   = stop_q | stop;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        stop_d    = stop_q;
        err_d     = err_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    stop_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                stop_d = stop_go;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                stop_d = stop_go;
                if (oper_type == HALT_OP) begin
                    state_d = S_HALT;
                end else if (oper_type > OP_MUL) begin
                    err_d   = 1'b1;
                    state_d = stop_go ? S_IDLE : S_FETCH;
                end else begin
                    cnt_d   = (oper_type == OP_MUL) ? MUL_CNT : 4'd0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                stop_d = stop_go;
                if (cnt_q == 4'd0) state_d = S_WB;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_WB: begin
                stop_d    = stop_go;
                retired_d = retired_q + 16'd1;
                state_d   = stop_go ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    pc_d      = '0;
                    err_d     = 1'b0;
                    retired_d = '0;
                    stop_d    = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            cnt_q      <= '0;
            stop_q     <= 1'b0;
            err_q      <= 1'b0;
            retired_q  <= '0;
            imem_req_q <= 1'b0;
            exec_en_q  <= 1'b0;
            gpr_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            stop_q     <= stop_d;
            err_q      <= err_d;
            retired_q  <= retired_d;
            imem_req_q <= (state_d == S_FETCH);
            exec_en_q  <= (state_d == S_EXEC);
            gpr_we_q   <= (state_d == S_WB);
            busy_q     <= (state_d != S_IDLE) && (state_d != S_HALT);
            halted_q   <= (state_d == S_HALT);
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign exec_en   = exec_en_q;
    assign gpr_we    = gpr_we_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign err       = err_q;
    assign retired   = retired_q;

endmodule
